// File: rtl/round_controller.sv
// round_controller: sequences countdown, play, elimination, winner/draw and
// the per-character win tally that decides the match.
// Ports: debouncingclock/reset (sync, active-high); healthmage, healthgunman,
//   healthswordman, healthfistman {ID,health}; start_btn restarts after match.
//   Outputs (all registered): state, countdown, freeze, round_reset, alive,
//   winner, winner_valid, draw, wins (2 bits per character, alive order).
// Optional macro ROUND_TIMEOUT_EN: PLAY ends after ROUND_TIMEOUT cycles,
//   crediting the strictly healthiest survivor (tie gives a draw).
module round_controller #(
  parameter int COUNTDOWN_TICKS  = 100,
  parameter int COUNTDOWN_DIGITS = 3,
  parameter int OVER_HOLD        = 300,
  parameter int WINS_TO_MATCH    = 3,
  parameter int ROUND_TIMEOUT    = 3000
) (
  input  logic       debouncingclock,
  input  logic       reset,
  input  logic [5:0] healthmage,
  input  logic [5:0] healthgunman,
  input  logic [5:0] healthswordman,
  input  logic [5:0] healthfistman,
  input  logic       start_btn,
  output logic [1:0] state,
  output logic [3:0] countdown,
  output logic       freeze,
  output logic       round_reset,
  output logic [3:0] alive,
  output logic [1:0] winner,
  output logic       winner_valid,
  output logic       draw,
  output logic [7:0] wins
);

  typedef enum logic [1:0] {
    COUNTDOWN  = 2'b00,
    PLAY       = 2'b01,
    ROUND_OVER = 2'b10,
    MATCH_OVER = 2'b11
  } state_t;

  localparam int CMAX0 = (COUNTDOWN_TICKS > OVER_HOLD) ?
                         COUNTDOWN_TICKS : OVER_HOLD;
`ifdef ROUND_TIMEOUT_EN
  localparam int CMAX = (CMAX0 > ROUND_TIMEOUT) ? CMAX0 : ROUND_TIMEOUT;
`else
  localparam int CMAX = CMAX0;
  localparam int unused_timeout = ROUND_TIMEOUT;
`endif
  localparam int CW = $clog2(CMAX + 1);

  state_t        st;
  logic [CW-1:0] cnt;
  logic          start_q;

  logic [3:0] hp [4];
  logic [3:0] alive_n;
  logic [2:0] n_alive;
  logic [1:0] sole_idx;
  logic       fin;
  logic       fin_draw;
  logic [1:0] fin_idx;
  logic [7:0] wins_cr;
  logic       match_done;
  logic       start_rise;
  logic       unused_id;

  assign state = st;
  assign hp[0] = healthmage[3:0];
  assign hp[1] = healthgunman[3:0];
  assign hp[2] = healthswordman[3:0];
  assign hp[3] = healthfistman[3:0];
  assign unused_id = ^{healthmage[5:4], healthgunman[5:4],
                       healthswordman[5:4], healthfistman[5:4]};
  assign start_rise = start_btn & ~start_q;

  // Eliminations are sticky: a zero health clears the bit for the round.
  always_comb begin
    alive_n = alive;
    for (int i = 0; i < 4; i++)
      if (hp[i] == 4'd0) alive_n[i] = 1'b0;
  end

  always_comb begin
    n_alive = 3'(alive_n[0]) + 3'(alive_n[1]) +
              3'(alive_n[2]) + 3'(alive_n[3]);
    sole_idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (alive_n[i]) sole_idx = 2'(i);
  end

`ifdef ROUND_TIMEOUT_EN
  logic [3:0] top;
  logic [1:0] top_idx;
  logic [2:0] top_cnt;

  always_comb begin
    top     = 4'd0;
    top_idx = 2'd0;
    top_cnt = 3'd0;
    for (int i = 0; i < 4; i++)
      if (alive_n[i] && hp[i] > top) begin
        top     = hp[i];
        top_idx = 2'(i);
      end
    for (int i = 0; i < 4; i++)
      if (alive_n[i] && hp[i] == top) top_cnt = top_cnt + 3'd1;
  end
`endif

  // Elimination ending wins over a coincident timeout.
  always_comb begin
    fin      = (n_alive <= 3'd1);
    fin_draw = (n_alive == 3'd0);
    fin_idx  = sole_idx;
`ifdef ROUND_TIMEOUT_EN
    if (!fin && cnt == CW'(ROUND_TIMEOUT - 1)) begin
      fin      = 1'b1;
      fin_draw = (top_cnt > 3'd1);
      fin_idx  = top_idx;
    end
`endif
  end

  always_comb begin
    wins_cr = wins;
    if (wins[{fin_idx, 1'b0} +: 2] < 2'(WINS_TO_MATCH))
      wins_cr[{fin_idx, 1'b0} +: 2] = wins[{fin_idx, 1'b0} +: 2] + 2'd1;
  end

  always_comb begin
    match_done = 1'b0;
    for (int i = 0; i < 4; i++)
      if (wins[2*i +: 2] == 2'(WINS_TO_MATCH)) match_done = 1'b1;
  end

  always_ff @(posedge debouncingclock) begin
    if (reset) begin
      st           <= COUNTDOWN;
      countdown    <= 4'(COUNTDOWN_DIGITS);
      cnt          <= '0;
      freeze       <= 1'b1;
      round_reset  <= 1'b0;
      alive        <= 4'b1111;
      winner       <= 2'd0;
      winner_valid <= 1'b0;
      draw         <= 1'b0;
      wins         <= 8'd0;
      start_q      <= 1'b1;
    end else begin
      start_q     <= start_btn;
      round_reset <= 1'b0;
      unique case (st)
        COUNTDOWN: begin
          alive <= 4'b1111;
          if (cnt == CW'(COUNTDOWN_TICKS - 1)) begin
            cnt <= '0;
            if (countdown == 4'd1) begin
              st        <= PLAY;
              countdown <= 4'd0;
              freeze    <= 1'b0;
            end else begin
              countdown <= countdown - 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PLAY: begin
          alive <= alive_n;
          cnt   <= cnt + 1'b1;
          if (fin) begin
            st     <= ROUND_OVER;
            freeze <= 1'b1;
            cnt    <= '0;
            if (fin_draw) begin
              draw         <= 1'b1;
              winner_valid <= 1'b0;
            end else begin
              winner       <= fin_idx;
              winner_valid <= 1'b1;
              draw         <= 1'b0;
              wins         <= wins_cr;
            end
          end
        end
        ROUND_OVER: begin
          if (cnt == CW'(OVER_HOLD - 1)) begin
            cnt <= '0;
            if (match_done) begin
              st           <= MATCH_OVER;
              winner_valid <= 1'b1;
            end else begin
              st           <= COUNTDOWN;
              countdown    <= 4'(COUNTDOWN_DIGITS);
              round_reset  <= 1'b1;
              alive        <= 4'b1111;
              winner_valid <= 1'b0;
              draw         <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MATCH_OVER: begin
          if (start_rise) begin
            st           <= COUNTDOWN;
            countdown    <= 4'(COUNTDOWN_DIGITS);
            cnt          <= '0;
            round_reset  <= 1'b1;
            alive        <= 4'b1111;
            winner_valid <= 1'b0;
            draw         <= 1'b0;
            wins         <= 8'd0;
          end
        end
        default: st <= COUNTDOWN;
      endcase
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: random health/button/reset stimulus, reference model
// predicts every output cycle; a monitor pops predictions and compares.
module tb_round_controller;

  localparam int TK   = 4;
  localparam int DG   = 3;
  localparam int HOLD = 5;
  localparam int WM   = 2;
  localparam int TO   = 20;
  localparam int NCYC = 6000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] hm, hg, hs, hf;
  logic       start_btn = 1'b1;
  logic [1:0] state;
  logic [3:0] countdown;
  logic       freeze, round_reset;
  logic [3:0] alive;
  logic [1:0] winner;
  logic       winner_valid, draw;
  logic [7:0] wins;

  always #5 clk = ~clk;

  round_controller #(
    .COUNTDOWN_TICKS(TK),
    .COUNTDOWN_DIGITS(DG),
    .OVER_HOLD(HOLD),
    .WINS_TO_MATCH(WM),
    .ROUND_TIMEOUT(TO)
  ) dut (
    .debouncingclock(clk),
    .reset(reset),
    .healthmage(hm),
    .healthgunman(hg),
    .healthswordman(hs),
    .healthfistman(hf),
    .start_btn(start_btn),
    .state(state),
    .countdown(countdown),
    .freeze(freeze),
    .round_reset(round_reset),
    .alive(alive),
    .winner(winner),
    .winner_valid(winner_valid),
    .draw(draw),
    .wins(wins)
  );

  // Reference model: phase 0 countdown, 1 play, 2 round over, 3 match over.
  int       ph;
  int       el;
  int       pc;
  bit [3:0] m_alive;
  int       m_win;
  bit       m_wv, m_dr, m_rr, m_pb;
  int       m_wins [4];
  int       hv [4];

  logic [23:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [23:0] pack_model();
    logic [3:0] cd;
    logic [7:0] w;
    cd = (ph == 0) ? 4'(DG - el / TK) : 4'd0;
    w = {2'(m_wins[3]), 2'(m_wins[2]), 2'(m_wins[1]), 2'(m_wins[0])};
    return {2'(ph), cd, (ph != 1), m_rr, m_alive, 2'(m_win),
            m_wv, m_dr, w};
  endfunction

  task automatic new_round();
    ph = 0;
    el = 0;
    m_alive = 4'hf;
    m_rr = 1'b1;
    m_wv = 1'b0;
    m_dr = 1'b0;
  endtask

  task automatic credit(input int idx);
    m_win = idx;
    m_wv = 1'b1;
    m_dr = 1'b0;
    if (m_wins[idx] < WM) m_wins[idx] = m_wins[idx] + 1;
  endtask

  task automatic model_step(input bit rst, input bit btn);
    int n;
    bit any;
    m_rr = 1'b0;
    if (rst) begin
      ph = 0; el = 0; pc = 0;
      m_alive = 4'hf;
      m_win = 0; m_wv = 0; m_dr = 0; m_pb = 1;
      for (int i = 0; i < 4; i++) m_wins[i] = 0;
      return;
    end
    case (ph)
      0: begin
        m_alive = 4'hf;
        el++;
        if (el == DG * TK) begin
          ph = 1; el = 0; pc = 0;
        end
      end
      1: begin
        for (int i = 0; i < 4; i++)
          if (hv[i] == 0) m_alive[i] = 1'b0;
        n = $countones(m_alive);
        if (n == 1) begin
          for (int i = 0; i < 4; i++)
            if (m_alive[i]) credit(i);
          ph = 2; el = 0;
        end else if (n == 0) begin
          m_dr = 1'b1; m_wv = 1'b0;
          ph = 2; el = 0;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (pc == TO - 1) begin
          int best, nbest, bi;
          best = -1; nbest = 0; bi = 0;
          for (int i = 0; i < 4; i++)
            if (m_alive[i] && hv[i] > best) begin
              best = hv[i]; bi = i;
            end
          for (int i = 0; i < 4; i++)
            if (m_alive[i] && hv[i] == best) nbest++;
          if (nbest > 1) begin
            m_dr = 1'b1; m_wv = 1'b0;
          end else begin
            credit(bi);
          end
          ph = 2; el = 0;
        end
`endif
        pc++;
      end
      2: begin
        el++;
        if (el == HOLD) begin
          any = 0;
          for (int i = 0; i < 4; i++)
            if (m_wins[i] == WM) any = 1;
          if (any) begin
            ph = 3; el = 0; m_wv = 1'b1;
          end else begin
            new_round();
          end
        end
      end
      default: begin
        if (btn && !m_pb) begin
          for (int i = 0; i < 4; i++) m_wins[i] = 0;
          new_round();
        end
      end
    endcase
    m_pb = btn;
  endtask

  // Monitor: outputs are presented every cycle; compare after each edge.
  initial begin
    logic [23:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, countdown, freeze, round_reset, alive, winner,
             winner_valid, draw, wins};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got=%h exp=%h (st/cd/fr/rr/al/wn/wv/dr/wins)",
                   $time, a, e);
        end
      end
    end
  end

  initial begin
    bit rst, btn;
    int budget;
    hv = '{10, 10, 10, 10};
    btn = 1'b1;
    hm = 6'd10; hg = 6'd10; hs = 6'd10; hf = 6'd10;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      rst = (c < 3) || ($urandom % 500 == 0) ||
            (ph == 2 && $urandom % 40 == 0);
      if ($urandom % 40 == 0) begin
        for (int i = 0; i < 4; i++) hv[i] = 0;
      end else begin
        for (int i = 0; i < 4; i++)
          hv[i] = ($urandom % 12 == 0) ? 0 : int'($urandom_range(1, 15));
      end
      if (c >= 3 && $urandom % 6 == 0) btn = ~btn;
      reset = rst;
      start_btn = btn;
      hm = {2'd0, 4'(hv[0])};
      hg = {2'd1, 4'(hv[1])};
      hs = {2'd2, 4'(hv[2])};
      hf = {2'd3, 4'(hv[3])};
      model_step(rst, btn);
      exp_q.push_back(pack_model());
    end
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
